// File: rtl/difftest_step_pkg.sv
// Shared types and elaboration helpers for the difftest step batcher.
// Exposes the FSM state enum, the adder sum width and the in_stall threshold.
package difftest_step_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Bits needed to hold the sum of all per-core reports.
  function automatic int sum_w(input int step_w, input int cores);
    return step_w + $clog2(cores);
  endfunction

  // Highest accumulator value that can still absorb one full-scale cycle
  // from every core; at or above it the cores are told to hold.
  function automatic longint stall_th(input int acc_w,
                                      input int step_w,
                                      input int cores);
    longint full;
    longint step_max;
    full     = (longint'(1) << acc_w) - 1;
    step_max = (longint'(1) << step_w) - 1;
    return full - longint'(cores) * step_max;
  endfunction

endpackage

// File: rtl/difftest_step_adder.sv
// Combinational masked sum of NUM_CORES step reports, zero-extended to ACC_W.
// Ports: valid (per-core mask), step (packed reports), sum (ACC_W result).
module difftest_step_adder
  import difftest_step_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int STEP_W    = 8,
  parameter int ACC_W     = 16
) (
  input  logic [NUM_CORES-1:0]        valid,
  input  logic [NUM_CORES*STEP_W-1:0] step,
  output logic [ACC_W-1:0]            sum
);

  localparam int SW = sum_w(STEP_W, NUM_CORES);

  logic [SW-1:0] part;

  always_comb begin
    part = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (valid[i]) begin
        part = part + SW'(step[i*STEP_W +: STEP_W]);
      end
    end
  end

  assign sum = ACC_W'(part);

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-core commit-step reports into one valid/ready stream for the
// host step consumer, draining and halting once the host posts a nonzero
// sim_result. Ports: clock, reset (sync, active-low), in_valid/in_step
// from cores, in_stall back-pressure, out_valid/out_ready/out_step to host,
// sim_result from host, halted status. Define DIFFTEST_STEP_BATCH_PERF_EN to
// add the perf_flushes / perf_stalls counters and ports.
module difftest_step_batcher
  import difftest_step_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int STEP_W       = 8,
  parameter int ACC_W        = 16,
  parameter int FLUSH_THRESH = 64,
  parameter int TIMEOUT      = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        in_valid,
  input  logic [NUM_CORES*STEP_W-1:0] in_step,
  output logic                        in_stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_step,
  input  logic [7:0]                  sim_result,
  output logic                        halted
`ifdef DIFFTEST_STEP_BATCH_PERF_EN
  ,
  output logic [31:0]                 perf_flushes,
  output logic [31:0]                 perf_stalls
`endif
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [ACC_W-1:0] STALL_TH =
    ACC_W'(stall_th(ACC_W, STEP_W, NUM_CORES));
  localparam logic [ACC_W-1:0] THRESH = ACC_W'(FLUSH_THRESH);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [TW-1:0]    timer;

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] inc_eff;
  logic [ACC_W-1:0] total;
  logic [ACC_W-1:0] acc_n;
  logic [TW-1:0]    timer_n;
  logic             accept;
  logic             hs;
  logic             can_flush;
  logic             nz;
  logic             thr_hit;
  logic             tmo_hit;
  logic             res_hit;
  logic             flush;

  difftest_step_adder #(
    .NUM_CORES (NUM_CORES),
    .STEP_W    (STEP_W),
    .ACC_W     (ACC_W)
  ) u_adder (
    .valid (in_valid),
    .step  (in_step),
    .sum   (inc)
  );

  // Reports count only in RUN; the cycle sim_result first hits is still RUN.
  assign accept    = (state == RUN) && !in_stall;
  assign inc_eff   = accept ? inc : '0;
  assign total     = acc + inc_eff;
  assign nz        = (total != '0);
  assign hs        = out_valid && out_ready;
  assign can_flush = !out_valid || out_ready;
  assign thr_hit   = (total >= THRESH);
  assign tmo_hit   = (TIMEOUT != 0) && (timer == TMAX) && nz;
  assign res_hit   = (sim_result != 8'd0) && nz;

  always_comb begin
    flush = 1'b0;
    unique case (1'b1)
      (state == RUN):   flush = can_flush && (thr_hit || tmo_hit || res_hit);
      (state == DRAIN): flush = can_flush && nz;
      default:          flush = 1'b0;
    endcase
  end

  assign acc_n = flush ? '0 : total;

  always_comb begin
    timer_n = '0;
    if (!flush && nz) begin
      timer_n = (timer == TMAX) ? timer : timer + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RUN;
      acc       <= '0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_step  <= '0;
      in_stall  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      unique case (state)
        RUN, DRAIN: begin
          acc       <= acc_n;
          timer     <= timer_n;
          out_valid <= flush || (out_valid && !hs);
          in_stall  <= (acc_n >= STALL_TH);
          if (flush) begin
            out_step <= total;
          end
          if (state == RUN && sim_result != 8'd0) begin
            state <= DRAIN;
          end
          if (state == DRAIN && !out_valid && acc == '0) begin
            state     <= HALT;
            halted    <= 1'b1;
            out_valid <= 1'b0;
            in_stall  <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_stall  <= 1'b0;
          halted    <= 1'b1;
        end
      endcase
    end
  end

`ifdef DIFFTEST_STEP_BATCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_flushes <= '0;
      perf_stalls  <= '0;
    end else begin
      if (hs) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
      if (in_stall) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: vector table plus hand sequences
// for timeout, back-pressure/overflow, drain/halt and mid-flush reset.
module tb_difftest_step_batcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [15:0] in_step;
  logic        in_stall;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_step;
  logic [7:0]  sim_result;
  logic        halted;
`ifdef DIFFTEST_STEP_BATCH_PERF_EN
  logic [31:0] perf_flushes;
  logic [31:0] perf_stalls;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  difftest_step_batcher dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_step    (in_step),
    .in_stall   (in_stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_step   (out_step),
    .sim_result (sim_result),
    .halted     (halted)
`ifdef DIFFTEST_STEP_BATCH_PERF_EN
    ,
    .perf_flushes (perf_flushes),
    .perf_stalls  (perf_stalls)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic        rdy;
    logic [7:0]  res;
    logic        e_valid;
    logic [15:0] e_step;
    logic        e_stall;
    logic        e_halt;
  } vec_t;

  vec_t tbl[19];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] s0,
                       input logic [7:0] s1, input logic rdy,
                       input logic [7:0] res);
    in_valid   = v;
    in_step    = {s1, s0};
    out_ready  = rdy;
    sim_result = res;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'd0, 8'd0, 1'b0, 8'd0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int bad;
    int seen;
    int sum_in;
    int sum_out;
    logic [15:0] held;

    // v, s0, s1, rdy, res, e_valid, e_step, e_stall, e_halt
    tbl[0]  = '{2'b11,  8,  8, 1, 0, 0,   0, 0, 0};
    tbl[1]  = '{2'b11,  8,  8, 1, 0, 0,   0, 0, 0};
    tbl[2]  = '{2'b11,  8,  8, 1, 0, 0,   0, 0, 0};
    tbl[3]  = '{2'b11,  8,  8, 1, 0, 1,  64, 0, 0};
    tbl[4]  = '{2'b11,  8,  8, 1, 0, 0,  64, 0, 0};
    tbl[5]  = '{2'b11,  8,  8, 1, 0, 0,  64, 0, 0};
    tbl[6]  = '{2'b11,  8,  8, 1, 0, 0,  64, 0, 0};
    tbl[7]  = '{2'b11,  8,  8, 1, 0, 1,  64, 0, 0};
    tbl[8]  = '{2'b01, 100, 0, 0, 0, 1,  64, 0, 0};
    tbl[9]  = '{2'b10,  0,  5, 0, 0, 1,  64, 0, 0};
    tbl[10] = '{2'b00,  0,  0, 1, 0, 1, 105, 0, 0};
    tbl[11] = '{2'b11,  3,  7, 0, 0, 1, 105, 0, 0};
    tbl[12] = '{2'b00,  0,  0, 0, 3, 1, 105, 0, 0};
    tbl[13] = '{2'b11, 50, 50, 0, 0, 1, 105, 0, 0};
    tbl[14] = '{2'b00,  0,  0, 1, 0, 1,  10, 0, 0};
    tbl[15] = '{2'b00,  0,  0, 1, 0, 0,  10, 0, 0};
    tbl[16] = '{2'b00,  0,  0, 1, 0, 0,  10, 0, 1};
    tbl[17] = '{2'b11, 200, 200, 1, 5, 0, 10, 0, 1};
    tbl[18] = '{2'b11, 200, 200, 1, 0, 0, 10, 0, 1};

    reset = 1'b0;
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_step", 32'(out_step), 0);
    chk("rst_stall", 32'(in_stall), 0);
    chk("rst_halt", 32'(halted), 0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].rdy, tbl[i].res);
      tick();
      nvec++;
      if (out_valid !== tbl[i].e_valid || out_step !== tbl[i].e_step ||
          in_stall !== tbl[i].e_stall || halted !== tbl[i].e_halt) begin
        nerr++;
        $display("FAIL vec%0d: got v=%0d s=%0d st=%0d h=%0d expected v=%0d s=%0d st=%0d h=%0d",
                 i, out_valid, out_step, in_stall, halted, tbl[i].e_valid,
                 tbl[i].e_step, tbl[i].e_stall, tbl[i].e_halt);
      end
    end

    // Timeout: a lone report of 1 surfaces exactly TIMEOUT cycles later.
    do_reset();
    drive(2'b01, 8'd1, 8'd0, 1'b1, 8'd0);
    tick();
    drive(2'b00, 8'd0, 8'd0, 1'b1, 8'd0);
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 255);
    chk("tmo_step", 32'(out_step), 1);

    // Back-pressure: full-scale reports with the consumer stalled.
    do_reset();
    drive(2'b11, 8'd255, 8'd255, 1'b0, 8'd0);
    sum_in = 0;
    bad = 0;
    seen = 0;
    held = 16'd0;
    for (int i = 0; i < 200; i++) begin
      if (!in_stall) sum_in += 510;
      tick();
      if (i == 0) held = out_step;
      else if (out_step !== held || !out_valid) bad++;
      if (in_stall) seen = 1;
    end
    chk("bp_first", 32'(held), 510);
    chk("bp_stable", 32'(bad), 0);
    chk("bp_stall", 32'(seen), 1);
    chk("bp_accepted", 32'(sum_in), 65790);
    drive(2'b00, 8'd0, 8'd0, 1'b1, 8'd0);
    sum_out = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_ready) sum_out += int'(out_step);
      tick();
    end
    chk("bp_no_loss", 32'(sum_out), 32'(sum_in));
    chk("bp_unstall", 32'(in_stall), 0);
    chk("bp_idle", 32'(out_valid), 0);

    // Reset while a batch is held by the consumer.
    do_reset();
    drive(2'b11, 8'd8, 8'd8, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("mr_pending", 32'(out_valid), 1);
    reset = 1'b0;
    tick();
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_step", 32'(out_step), 0);
    chk("mr_halt", 32'(halted), 0);
    reset = 1'b1;
    drive(2'b11, 8'd8, 8'd8, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("mr_acc0", 32'(out_valid), 0);
    tick();
    chk("mr_run", 32'(out_step), 64);

`ifdef DIFFTEST_STEP_BATCH_PERF_EN
    do_reset();
    drive(2'b11, 8'd8, 8'd8, 1'b1, 8'd0);
    for (int i = 0; i < 100; i++) tick();
    drive(2'b00, 8'd0, 8'd0, 1'b1, 8'd0);
    tick();
    tick();
    chk("perf_flushes", perf_flushes, 25);
    chk("perf_stalls", perf_stalls, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
